// File: rtl/prio_encoder_rr_pkg.sv
// rtl/prio_encoder_rr_pkg.sv - shared types, mode constants and pointer helper for prio_encoder_rr
// Package prio_enc_pkg:
//   MODE_FIXED / MODE_RR : arbitration mode selectors
//   state_t              : output register occupancy (EMPTY / FULL)
//   next_ptr(idx, n)     : modulo-n increment, wraps at n rather than at a power of two
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// rtl/prio_encoder_rr_if.sv - request/result handshake bundle for prio_encoder_rr
// Signals:
//   in_valid / in_ready / in_req         : request side
//   out_valid / out_ready                : result side handshake
//   out_idx / out_zero                   : encoded winner, all-zero flag
//   out_onehot                           : one-hot winner (PRIO_ENCODER_ONEHOT_OUT_EN only)
// Modports: master = request source + result consumer, slave = the encoder.
interface prio_encoder_rr_if #(
  parameter int N = 4,
  parameter int W = $clog2(N)
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_zero;
`ifdef PRIO_ENCODER_ONEHOT_OUT_EN
  logic [N-1:0] out_onehot;
`endif

  modport master (
`ifdef PRIO_ENCODER_ONEHOT_OUT_EN
    input  out_onehot,
`endif
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_zero
  );

  modport slave (
`ifdef PRIO_ENCODER_ONEHOT_OUT_EN
    output out_onehot,
`endif
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_zero
  );

endinterface

// File: rtl/prio_encoder_rr_search.sv
// rtl/prio_encoder_rr_search.sv - combinational winner search (module prio_enc_search)
// Ports:
//   req   [N-1:0] in  : request vector
//   start [W-1:0] in  : round-robin search origin (ignored in fixed mode)
//   mode          in  : 0 = highest set index wins, 1 = ascending search from start with wrap at N
//   idx   [W-1:0] out : winning index, 0 when req is all zeros
//   zero          out : req is all zeros
module prio_enc_search #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         zero
);

  int           pos;
  logic [W-1:0] pos_w;
  logic         found;

  always_comb begin
    idx   = '0;
    zero  = ~|req;
    pos   = 0;
    pos_w = '0;
    found = 1'b0;
    if (mode) begin
      // start is always < N, so a single subtraction is enough to wrap
      for (int i = 0; i < N; i++) begin
        pos = int'(start) + i;
        if (pos >= N) pos = pos - N;
        pos_w = W'(pos);
        if (!found && req[pos_w]) begin
          idx   = pos_w;
          found = 1'b1;
        end
      end
    end else begin
      // ascending scan, the last hit is the highest set index
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered fixed/round-robin priority encoder with valid/ready handshake
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, drops any pending result
//   bus  : prio_encoder_rr_if.slave (in_valid/in_ready/in_req, out_valid/out_ready/out_idx/out_zero)
// Parameters: N request bits, W index width, MODE 0 = fixed, 1 = round-robin.
// Optional: PRIO_ENCODER_ONEHOT_OUT_EN adds registered out_onehot.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = $clog2(N),
  parameter int MODE = MODE_FIXED
) (
  input  logic            clk,
  input  logic            rst,
  prio_encoder_rr_if.slave bus
);

  state_t       state_q, state_d;
  logic [W-1:0] rr_ptr;
  logic [W-1:0] idx_q;
  logic         zero_q;
  logic [W-1:0] s_idx;
  logic         s_zero;
  logic         accept;
`ifdef PRIO_ENCODER_ONEHOT_OUT_EN
  logic [N-1:0] onehot_q;
  logic [N-1:0] onehot_one;
  assign onehot_one = {{(N-1){1'b0}}, 1'b1};
`endif

  prio_enc_search #(.N(N), .W(W)) u_search (
    .req   (bus.in_req),
    .start (rr_ptr),
    .mode  (MODE == MODE_RR),
    .idx   (s_idx),
    .zero  (s_zero)
  );

  // No skid buffer: a stalled result blocks the input directly
  assign bus.in_ready  = (state_q == ST_EMPTY) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_idx   = idx_q;
  assign bus.out_zero  = zero_q;
`ifdef PRIO_ENCODER_ONEHOT_OUT_EN
  assign bus.out_onehot = onehot_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)             state_d = ST_FULL;
        else if (bus.out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      rr_ptr  <= '0;
`ifdef PRIO_ENCODER_ONEHOT_OUT_EN
      onehot_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= s_idx;
        zero_q <= s_zero;
`ifdef PRIO_ENCODER_ONEHOT_OUT_EN
        onehot_q <= s_zero ? '0 : (onehot_one << s_idx);
`endif
        // fixed mode never moves the pointer; an empty request leaves it alone
        if (MODE == MODE_RR && !s_zero)
          rr_ptr <= W'(next_ptr(int'(s_idx), N));
      end
    end
  end

endmodule
